ocp_slave_fsm: RTL

OCP_SLAVE_FSM -- requirements
Module: ocp_slave_fsm

---
 rtl/ocp_slave_fsm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ocp_slave_fsm.sv
// OCP slave with burst FSM, optional accept stall and a small word memory.
// Define OCP_SLAVE_ERR_EN to report ERR for unsupported commands and out-of-range addresses.
module ocp_slave_fsm #(
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned ACCEPT_WAIT = 0,
  parameter int unsigned MADDR_WIDTH = 64,
  parameter int unsigned MDATA_WIDTH = 8,
  parameter int unsigned SDATA_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [MDATA_WIDTH-1:0] MData,
  input  logic [9:0]             MBurstLength,
  input  logic                   MReqLast,
  output logic                   SCmdAccept,
  output logic [1:0]             SResp,
  output logic [SDATA_WIDTH-1:0] SData,
  output logic                   SRespLast
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_RDEX = 3'b011;
  localparam logic [2:0] CMD_RDL  = 3'b100;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_e;

  state_e                 r_state, w_state_nxt;
  logic [2:0]             r_stall_cnt, w_stall_nxt;
  logic [9:0]             r_beat_cnt;
  logic [9:0]             r_burst_len;
  logic [MDATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [1:0]             r_sresp;
  logic [SDATA_WIDTH-1:0] r_sdata;
  logic                   r_sresp_last;

  logic             w_cmd_valid, w_accept, w_first, w_last;
  logic [IDX_W-1:0] w_idx;
  logic             w_addr_hi_nz, w_is_rd, w_is_wr, w_do_write, w_dva, w_err_resp;
  logic [9:0]       w_len;
  logic             w_unused_addr;

  assign w_cmd_valid   = (MCmd != CMD_IDLE);
  assign w_idx         = MAddr[IDX_W+1:2];
  assign w_addr_hi_nz  = |MAddr[MADDR_WIDTH-1:IDX_W+2];
  assign w_unused_addr = ^MAddr[1:0];
  assign w_len         = (MBurstLength == 10'd0) ? 10'd1 : MBurstLength;

`ifdef OCP_SLAVE_ERR_EN
  assign w_is_rd    = (MCmd == CMD_RD);
  assign w_is_wr    = (MCmd == CMD_WR);
  assign w_do_write = w_is_wr && !w_addr_hi_nz;
  assign w_err_resp = (w_cmd_valid && !w_is_rd && !w_is_wr) || (w_is_rd && w_addr_hi_nz);
`else
  // Upper address bits are ignored here; the index simply wraps.
  assign w_is_rd    = (MCmd == CMD_RD) || (MCmd == CMD_RDEX) || (MCmd == CMD_RDL);
  assign w_is_wr    = w_cmd_valid && !w_is_rd;
  assign w_do_write = w_is_wr && !(w_addr_hi_nz && 1'b0);
  assign w_err_resp = 1'b0;
`endif
  assign w_dva = w_is_rd && !w_err_resp;

  always_comb begin
    w_accept    = 1'b0;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_state_nxt = r_state;
    w_stall_nxt = r_stall_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_valid) begin
          if (ACCEPT_WAIT == 0) begin
            w_accept = 1'b1;
            w_first  = 1'b1;
          end else begin
            w_stall_nxt = 3'(ACCEPT_WAIT - 1);
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_cmd_valid) begin
          w_stall_nxt = 3'd0;
          w_state_nxt = S_IDLE;
        end else if (r_stall_cnt == 3'd0) begin
          w_accept = 1'b1;
          w_first  = 1'b1;
        end else begin
          w_stall_nxt = r_stall_cnt - 3'd1;
        end
      end
      S_BURST: w_accept = w_cmd_valid;
      default: w_state_nxt = S_IDLE;
    endcase

    if (reset) w_accept = 1'b0;

    if (w_accept) begin
      if (w_first) w_last = !((w_len > 10'd1) && !MReqLast);
      else         w_last = ((r_beat_cnt + 10'd1) == r_burst_len) || MReqLast;
      w_state_nxt = w_last ? S_IDLE : S_BURST;
    end
  end

  assign SCmdAccept = w_accept;
  assign SResp      = r_sresp;
  assign SData      = r_sdata;
  assign SRespLast  = r_sresp_last;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_stall_cnt  <= 3'd0;
      r_beat_cnt   <= 10'd0;
      r_burst_len  <= 10'd0;
      r_sresp      <= RESP_NULL;
      r_sdata      <= '0;
      r_sresp_last <= 1'b0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_cnt  <= w_stall_nxt;
      r_sresp      <= RESP_NULL;
      r_sdata      <= '0;
      r_sresp_last <= 1'b0;
      if (w_accept) begin
        if (w_first) begin
          r_burst_len <= w_len;
          r_beat_cnt  <= 10'd1;
        end else begin
          r_beat_cnt  <= r_beat_cnt + 10'd1;
        end
        if (w_do_write) r_mem[w_idx] <= MData;
        if (w_dva) begin
          r_sresp      <= RESP_DVA;
          r_sdata      <= SDATA_WIDTH'(r_mem[w_idx]);
          r_sresp_last <= w_last;
        end else if (w_err_resp) begin
          r_sresp      <= RESP_ERR;
          r_sresp_last <= w_last;
        end
      end
    end
  end

endmodule
